// File: rtl/grid_image_streamer.sv
// Streams the 28x28 one-bit canvas row-major as PIX_W-bit samples over valid/ready.
// Optional ink counter output enabled by defining GRID_STREAMER_INK_COUNT_EN.
module grid_image_streamer #(
  parameter int                GRID_SIZE = 28,
  parameter int                PIX_W     = 8,
  parameter logic [PIX_W-1:0]  ON_VALUE  = 8'd255,
  parameter logic [PIX_W-1:0]  OFF_VALUE = 8'd0
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [9:0]       mem_addr,
  input  logic             mem_rdata,
  output logic [PIX_W-1:0] out_data,
  output logic [9:0]       out_index,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready
`ifdef GRID_STREAMER_INK_COUNT_EN
  ,
  output logic [9:0]       ink_count
`endif
);

  localparam int FRAME = GRID_SIZE * GRID_SIZE;
  localparam int CW    = $clog2(GRID_SIZE);
  localparam logic [9:0]    LAST_IDX = 10'(FRAME - 1);
  localparam logic [CW-1:0] LAST_XY  = CW'(GRID_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    SEND
  } state_e;

  // DONE shares the IDLE encoding slot via a separate flag to keep 2 bits
  state_e           state_q, state_d;
  logic             in_done_q, in_done_d;
  logic [CW-1:0]    x_q, x_d;
  logic [CW-1:0]    y_q, y_d;
  logic [9:0]       idx_q, idx_d;
  logic [PIX_W-1:0] data_q, data_d;
  logic [9:0]       oidx_q, oidx_d;
  logic             last_q, last_d;
  logic             valid_q, valid_d;
  logic             set_q, set_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [9:0]       ink_q, ink_d;

  always_comb begin
    state_d   = state_q;
    in_done_d = 1'b0;
    x_d       = x_q;
    y_d       = y_q;
    idx_d     = idx_q;
    data_d    = data_q;
    oidx_d    = oidx_q;
    last_d    = last_q;
    valid_d   = valid_q;
    set_d     = set_q;
    done_d    = 1'b0;
    ink_d     = ink_q;
    unique case (state_q)
      IDLE: begin
        if (start && !in_done_q) begin
          state_d = ISSUE;
          x_d     = '0;
          y_d     = '0;
          idx_d   = '0;
          ink_d   = '0;
        end
      end
      ISSUE: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        data_d  = mem_rdata ? ON_VALUE : OFF_VALUE;
        set_d   = mem_rdata;
        oidx_d  = idx_q;
        last_d  = (idx_q == LAST_IDX);
        valid_d = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        if (out_ready) begin
          valid_d = 1'b0;
          ink_d   = ink_q + {9'd0, set_q};
          if (idx_q == LAST_IDX) begin
            last_d    = 1'b0;
            done_d    = 1'b1;
            in_done_d = 1'b1;
            state_d   = IDLE;
          end else begin
            idx_d   = idx_q + 10'd1;
            state_d = ISSUE;
            if (x_q == LAST_XY) begin
              x_d = '0;
              y_d = y_q + CW'(1);
            end else begin
              x_d = x_q + CW'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE) || in_done_d;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      in_done_q <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      idx_q     <= '0;
      data_q    <= '0;
      oidx_q    <= '0;
      last_q    <= 1'b0;
      valid_q   <= 1'b0;
      set_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ink_q     <= '0;
    end else begin
      state_q   <= state_d;
      in_done_q <= in_done_d;
      x_q       <= x_d;
      y_q       <= y_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      oidx_q    <= oidx_d;
      last_q    <= last_d;
      valid_q   <= valid_d;
      set_q     <= set_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ink_q     <= ink_d;
    end
  end

  assign mem_addr  = idx_q;
  assign out_data  = data_q;
  assign out_index = oidx_q;
  assign out_last  = last_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

`ifdef GRID_STREAMER_INK_COUNT_EN
  assign ink_count = ink_q;
`else
  logic unused_ink;
  assign unused_ink = ^ink_q;
`endif

endmodule

// File: tb/tb_grid_image_streamer.sv
// Randomised self-checking bench for grid_image_streamer against a canvas-array model.
module tb_grid_image_streamer;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       mem_rdata = 1'b0;
  logic       out_ready = 1'b0;
  logic       busy, done, out_last, out_valid;
  logic [9:0] mem_addr, out_index;
  logic [7:0] out_data;
`ifdef GRID_STREAMER_INK_COUNT_EN
  logic [9:0] ink_count;
`endif

  bit canvas [784];
  int checks = 0;
  int errors = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) mem_rdata <= canvas[mem_addr];

  grid_image_streamer dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef GRID_STREAMER_INK_COUNT_EN
    ,
    .ink_count (ink_count)
`endif
  );

  function automatic logic [7:0] exp_pix(int i);
    return canvas[i] ? 8'hFF : 8'h00;
  endfunction

  function automatic int popcount();
    int n = 0;
    for (int i = 0; i < 784; i++) n += int'(canvas[i]);
    return n;
  endfunction

  task automatic clear_canvas();
    for (int i = 0; i < 784; i++) canvas[i] = 1'b0;
  endtask

  task automatic rand_canvas();
    for (int i = 0; i < 784; i++) canvas[i] = 1'($urandom_range(1));
  endtask

  // Runs one frame from a start pulse, checking every observed cycle.
  task automatic stream(input string tag, input int rdy_pct,
                        input int hold_idx, input int poke_idx,
                        input int abort_at, input bit poke_done,
                        input bit chk_len);
    int exp_idx = 0;
    int cyc = 0;
    int hold = 0;
    int ink_exp;
    bit first = 1'b1;
    bit pv = 1'b0;
    bit pr = 1'b0;
    bit phs = 1'b0;
    bit fin = 1'b0;
    logic [7:0] pd = '0;
    logic [9:0] pi = '0;
    ink_exp = popcount();
    start = 1'b1;
    @(posedge CLOCK_50); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || mem_addr !== 10'd0) begin
      errors++;
      $display("FAIL %s start busy=%b addr=%0d want 1/0", tag, busy, mem_addr);
    end
`ifdef GRID_STREAMER_INK_COUNT_EN
    checks++;
    if (ink_count !== 10'd0) begin
      errors++;
      $display("FAIL %s ink_clear got %0d want 0", tag, ink_count);
    end
`endif
    while (!fin) begin
      if (cyc > 40000) begin
        errors++;
        $display("FAIL %s timeout got idx %0d want done", tag, exp_idx);
        fin = 1'b1;
      end else if (done === 1'b1) begin
        checks++;
        if (exp_idx != 784 || !phs || out_valid !== 1'b0 || out_last !== 1'b0) begin
          errors++;
          $display("FAIL %s done got idx %0d hs %0b v %b l %b want 784 1 0 0",
                   tag, exp_idx, phs, out_valid, out_last);
        end
        if (chk_len) begin
          checks++;
          if (cyc != 2352) begin
            errors++;
            $display("FAIL %s frame_len got %0d want 2352", tag, cyc);
          end
        end
        if (hold_idx >= 0) begin
          checks++;
          if (hold != 10) begin
            errors++;
            $display("FAIL %s hold_cycles got %0d want 10", tag, hold);
          end
        end
`ifdef GRID_STREAMER_INK_COUNT_EN
        checks++;
        if (ink_count !== 10'(ink_exp)) begin
          errors++;
          $display("FAIL %s ink_done got %0d want %0d", tag, ink_count, ink_exp);
        end
`endif
        if (poke_done) start = 1'b1;
        @(posedge CLOCK_50); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0) begin
          errors++;
          $display("FAIL %s after_done busy=%b done=%b v=%b want 0 0 0",
                   tag, busy, done, out_valid);
        end
        @(posedge CLOCK_50); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
          errors++;
          $display("FAIL %s idle busy=%b done=%b want 0 0", tag, busy, done);
        end
`ifdef GRID_STREAMER_INK_COUNT_EN
        checks++;
        if (ink_count !== 10'(ink_exp)) begin
          errors++;
          $display("FAIL %s ink_hold got %0d want %0d", tag, ink_count, ink_exp);
        end
`endif
        fin = 1'b1;
      end else begin
        if (phs && exp_idx < 784) begin
          checks++;
          if (mem_addr !== exp_idx[9:0]) begin
            errors++;
            $display("FAIL %s issue_addr got %0d want %0d", tag, mem_addr, exp_idx);
          end
        end
        if (out_valid === 1'b1) begin
          if (first) begin
            first = 1'b0;
            checks++;
            if (cyc != 2) begin
              errors++;
              $display("FAIL %s latency got %0d want 2", tag, cyc);
            end
          end
          checks++;
          if (out_index !== exp_idx[9:0] || out_data !== exp_pix(exp_idx) ||
              out_last !== (exp_idx == 783) || mem_addr !== out_index) begin
            errors++;
            $display("FAIL %s sample got i%0d d%h l%b a%0d want i%0d d%h l%0d",
                     tag, out_index, out_data, out_last, mem_addr,
                     exp_idx, exp_pix(exp_idx), exp_idx == 783);
          end
          if (pv && !pr) begin
            checks++;
            if (out_data !== pd || out_index !== pi) begin
              errors++;
              $display("FAIL %s stable got i%0d d%h want i%0d d%h",
                       tag, out_index, out_data, pi, pd);
            end
          end
        end else begin
          checks++;
          if ((pv && !pr) || out_last !== 1'b0) begin
            errors++;
            $display("FAIL %s valid_drop got v0 l%b want v1/l0", tag, out_last);
          end
        end
        if (abort_at >= 0 && out_valid === 1'b1 && out_index == 10'(abort_at)) begin
          reset = 1'b1;
          #1;
          checks++;
          if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0 ||
              out_last !== 1'b0 || out_data !== 8'd0 || out_index !== 10'd0 ||
              mem_addr !== 10'd0) begin
            errors++;
            $display("FAIL %s abort got b%b d%b v%b l%b %h %0d %0d want zeros",
                     tag, busy, done, out_valid, out_last, out_data,
                     out_index, mem_addr);
          end
          @(posedge CLOCK_50); #1;
          reset = 1'b0;
          checks++;
          if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s abort_done got d%b b%b want 0 0", tag, done, busy);
          end
          fin = 1'b1;
        end else begin
          if (hold_idx >= 0 && out_valid === 1'b1 &&
              out_index == 10'(hold_idx) && hold < 10) begin
            out_ready = 1'b0;
            hold++;
          end else begin
            out_ready = ($urandom_range(99) < rdy_pct);
          end
          start = (poke_idx >= 0 && out_valid === 1'b1 &&
                   out_index == 10'(poke_idx));
          phs = out_valid && out_ready;
          if (phs) exp_idx++;
          pv = out_valid;
          pr = out_ready;
          pd = out_data;
          pi = out_index;
          @(posedge CLOCK_50); #1;
          start = 1'b0;
          cyc++;
        end
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge CLOCK_50);
    #1;
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0 ||
        out_last !== 1'b0 || out_data !== 8'd0 || out_index !== 10'd0 ||
        mem_addr !== 10'd0) begin
      errors++;
      $display("FAIL reset got b%b d%b v%b l%b %h %0d %0d want zeros",
               busy, done, out_valid, out_last, out_data, out_index, mem_addr);
    end
    out_ready = 1'b1;
    @(posedge CLOCK_50); #1;
    out_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_ready got b%b v%b want 0 0", busy, out_valid);
    end
  endtask

  task automatic test_blank();
    clear_canvas();
    stream("blank", 100, -1, -1, -1, 1'b0, 1'b1);
  endtask

  task automatic test_single_cell();
    clear_canvas();
    canvas[2 * 28 + 3] = 1'b1;
    stream("single", 100, -1, -1, -1, 1'b0, 1'b1);
  endtask

  task automatic test_backpressure();
    rand_canvas();
    stream("bp", 100, 5, -1, -1, 1'b0, 1'b0);
  endtask

  task automatic test_start_ignored();
    rand_canvas();
    stream("ign", 100, -1, 100, -1, 1'b1, 1'b0);
    stream("second", 100, -1, -1, -1, 1'b0, 1'b1);
  endtask

  task automatic test_random_ready();
    rand_canvas();
    stream("rand", 55, -1, -1, -1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    rand_canvas();
    stream("abort", 80, -1, -1, 400, 1'b0, 1'b0);
    stream("restart", 90, -1, -1, -1, 1'b0, 1'b0);
  endtask

  task automatic test_ink_row();
    clear_canvas();
    for (int x = 0; x < 28; x++) canvas[14 * 28 + x] = 1'b1;
    stream("ink", 70, -1, -1, -1, 1'b0, 1'b0);
    clear_canvas();
    stream("ink_next", 100, -1, -1, -1, 1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_blank();
    test_single_cell();
    test_backpressure();
    test_start_ignored();
    test_random_ready();
    test_reset_mid();
    test_ink_row();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
